wb_axi_bridge: RTL and testbench



---
 rtl/wb_axi_bridge_pkg.sv | 25 ++
 rtl/wb_axi_bridge_if.sv | 54 +++++
 rtl/wb_axi_bridge_fifo.sv | 53 +++++
 rtl/wb_axi_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_wb_axi_bridge.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_axi_bridge_pkg.sv
// wb_axi_bridge_pkg: shared types and constants for the Wishbone to
// AXI4-Lite / AXI4-Stream bridge.
//   state_e      bridge FSM states
//   *_OFF        default register offsets inside the decode window
//   ERR_PATTERN  read data returned when a bus wait is aborted
package wb_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RADDR,
    ST_RDATA,
    ST_SSWAIT,
    ST_SMWAIT,
    ST_ACK
  } state_e;

  localparam logic [11:0] SS_OFF   = 12'h080;
  localparam logic [11:0] SM_OFF   = 12'h084;
  localparam logic [11:0] SSL_OFF  = 12'h088;
  localparam logic [11:0] STAT_OFF = 12'h08C;

  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_axi_bridge_if.sv
// wb_axi_bridge_if: every bus the bridge touches, bundled.
//   Wishbone slave side : wb_valid, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
//                         wbs_ack_o, wbs_dat_o
//   AXI-Lite master     : aw*, w* (no B channel), ar*, r*
//   AXIS master (ss_*)  : stream out of the posted FIFO
//   AXIS slave  (sm_*)  : stream popped by reads of the SM offset
// modport slave  - the bridge's view (it is the Wishbone slave)
// modport master - the surrounding system: WB master, AXI slave, AXIS peers
interface wb_axi_bridge_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                     wb_valid;
  logic                     wbs_we_i;
  logic [pDATA_WIDTH/8-1:0] wbs_sel_i;
  logic [pDATA_WIDTH-1:0]   wbs_dat_i;
  logic [31:0]              wbs_adr_i;
  logic                     wbs_ack_o;
  logic [pDATA_WIDTH-1:0]   wbs_dat_o;

  logic                     awvalid, awready;
  logic [pADDR_WIDTH-1:0]   awaddr;
  logic                     wvalid, wready;
  logic [pDATA_WIDTH-1:0]   wdata;
  logic [pDATA_WIDTH/8-1:0] wstrb;

  logic                     arvalid, arready;
  logic [pADDR_WIDTH-1:0]   araddr;
  logic                     rvalid, rready;
  logic [pDATA_WIDTH-1:0]   rdata;

  logic                     ss_tvalid, ss_tready, ss_tlast;
  logic [pDATA_WIDTH-1:0]   ss_tdata;
  logic                     sm_tvalid, sm_tready, sm_tlast;
  logic [pDATA_WIDTH-1:0]   sm_tdata;

  modport slave (
    input  wb_valid, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o,
    output awvalid, awaddr, wvalid, wdata, wstrb, input awready, wready,
    output arvalid, araddr, rready, input arready, rvalid, rdata,
    output ss_tvalid, ss_tdata, ss_tlast, input ss_tready,
    output sm_tready, input sm_tvalid, sm_tdata, sm_tlast
  );

  modport master (
    output wb_valid, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o,
    input  awvalid, awaddr, wvalid, wdata, wstrb, output awready, wready,
    input  arvalid, araddr, rready, output arready, rvalid, rdata,
    input  ss_tvalid, ss_tdata, ss_tlast, output ss_tready,
    input  sm_tready, output sm_tvalid, sm_tdata, sm_tlast
  );
endinterface

// File: rtl/wb_axi_bridge_fifo.sv
// bridge_fifo: synchronous FIFO for the posted stream-out path.
//   clk, rst      clock, asynchronous active-high reset (flushes)
//   push, din     write side; a push while full is taken only with a pop
//   pop, dout     read side; dout is 0 while empty
//   full, empty   status flags
//   count         entries held (0..DEPTH)
module bridge_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Gate the read port so the stream data reads 0 after reset/flush.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/wb_axi_bridge.sv
// wb_axi_bridge: Wishbone slave to AXI4-Lite master + AXI4-Stream bridge.
//   wb_clk_i  clock
//   wb_rst_i  asynchronous active-high reset
//   bus       wb_axi_bridge_if.slave: WB slave, AXI-Lite master (AW/W/AR/R),
//             AXIS master ss_* fed from a posted FIFO, AXIS slave sm_*
// Decode inside [pBASE, pBASE + 2^pADDR_WIDTH): status register, stream-out
// push (with/without tlast), stream-in pop, everything else goes to AXI-Lite.
// Every wait state is bounded by a timeout that aborts with ERR_PATTERN.
module wb_axi_bridge
  import wb_axi_bridge_pkg::*;
#(
  parameter int                     pADDR_WIDTH = 12,
  parameter int                     pDATA_WIDTH = 32,
  parameter logic [31:0]            pBASE       = 32'h3000_3000,
  parameter logic [pADDR_WIDTH-1:0] pSS_OFF     = pADDR_WIDTH'(SS_OFF),
  parameter logic [pADDR_WIDTH-1:0] pSSL_OFF    = pADDR_WIDTH'(SSL_OFF),
  parameter logic [pADDR_WIDTH-1:0] pSM_OFF     = pADDR_WIDTH'(SM_OFF),
  parameter logic [pADDR_WIDTH-1:0] pSTAT_OFF   = pADDR_WIDTH'(STAT_OFF),
  parameter int                     pSS_DEPTH   = 4,
  parameter int                     pTIMEOUT    = 255
) (
  input logic             wb_clk_i,
  input logic             wb_rst_i,
  wb_axi_bridge_if.slave  bus
);
  localparam int CW = $clog2(pSS_DEPTH) + 1;
  // Abort on the edge that completes pTIMEOUT waiting cycles.
  localparam logic [7:0] TMO_LAST = 8'(pTIMEOUT - 1);
  localparam logic [pDATA_WIDTH-1:0] ERR_DAT = pDATA_WIDTH'(ERR_PATTERN);

  state_e                 state;
  logic [31:0]            off_full;
  logic [pADDR_WIDTH-1:0] off;
  logic                   in_win, hit_stat, hit_ss, hit_sm, is_last;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_cnt;
  logic [pDATA_WIDTH:0]   fifo_dout;
  logic                   err, sm_last;
  logic [7:0]             tmo_cnt;
  logic                   tmo_hit;
  logic [pDATA_WIDTH-1:0] status;

  always_comb begin
    off_full = bus.wbs_adr_i - pBASE;
    in_win   = (off_full >> pADDR_WIDTH) == 32'd0;
    off      = off_full[pADDR_WIDTH-1:0];
    hit_stat = (off == pSTAT_OFF);
    hit_ss   = !hit_stat && ((off == pSS_OFF) || (off == pSSL_OFF));
    hit_sm   = !hit_stat && !hit_ss && (off == pSM_OFF);
    is_last  = (off == pSSL_OFF);
    tmo_hit  = (tmo_cnt == TMO_LAST);

    // Push happens on the decode edge when there is room, otherwise from
    // SSWAIT; wbs_dat_i/adr are still held by the master in SSWAIT.
    fifo_push = 1'b0;
    case (state)
      ST_IDLE:   fifo_push = bus.wb_valid && in_win && hit_ss && bus.wbs_we_i && !fifo_full;
      ST_SSWAIT: fifo_push = !fifo_full;
      default:   ;
    endcase

    status              = '0;
    status[0]           = err;
    status[1]           = sm_last;
    status[8 +: 4]      = 4'(fifo_cnt);
  end

  assign fifo_pop      = bus.ss_tvalid && bus.ss_tready;
  assign bus.ss_tvalid = !fifo_empty;
  assign bus.ss_tdata  = fifo_dout[pDATA_WIDTH-1:0];
  assign bus.ss_tlast  = fifo_dout[pDATA_WIDTH];
  // Ready only while waiting and only when data is offered: exactly one beat.
  assign bus.sm_tready = (state == ST_SMWAIT) && bus.sm_tvalid;

  bridge_fifo #(
    .WIDTH (pDATA_WIDTH + 1),
    .DEPTH (pSS_DEPTH)
  ) u_ss_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (fifo_push),
    .din   ({is_last, bus.wbs_dat_i}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Handshake completion takes priority over the timeout on the same edge:
  // a beat that actually transferred must not be reported as aborted.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= ST_IDLE;
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
      bus.awvalid   <= 1'b0;
      bus.awaddr    <= '0;
      bus.wvalid    <= 1'b0;
      bus.wdata     <= '0;
      bus.wstrb     <= '0;
      bus.arvalid   <= 1'b0;
      bus.araddr    <= '0;
      bus.rready    <= 1'b0;
      err           <= 1'b0;
      sm_last       <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.wb_valid) begin
          tmo_cnt <= '0;
          if (!in_win || (hit_ss && !bus.wbs_we_i) || (hit_sm && bus.wbs_we_i)) begin
            state         <= ST_ACK;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= '0;
          end else if (hit_stat) begin
            if (bus.wbs_we_i && bus.wbs_dat_i[0]) err <= 1'b0;
            state         <= ST_ACK;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= bus.wbs_we_i ? '0 : status;
          end else if (hit_ss) begin
            if (fifo_full) state <= ST_SSWAIT;
            else begin
              state         <= ST_ACK;
              bus.wbs_ack_o <= 1'b1;
              bus.wbs_dat_o <= '0;
            end
          end else if (hit_sm) begin
            state <= ST_SMWAIT;
          end else if (bus.wbs_we_i) begin
            state       <= ST_WR;
            bus.awvalid <= 1'b1;
            bus.wvalid  <= 1'b1;
            bus.awaddr  <= off;
            bus.wdata   <= bus.wbs_dat_i;
            bus.wstrb   <= bus.wbs_sel_i;
          end else begin
            state       <= ST_RADDR;
            bus.arvalid <= 1'b1;
            bus.araddr  <= off;
          end
        end

        ST_WR: begin
          if (bus.awready) bus.awvalid <= 1'b0;
          if (bus.wready)  bus.wvalid  <= 1'b0;
          if ((!bus.awvalid || bus.awready) && (!bus.wvalid || bus.wready)) begin
            state         <= ST_ACK;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= '0;
          end else if (tmo_hit) begin
            bus.awvalid   <= 1'b0;
            bus.wvalid    <= 1'b0;
            err           <= 1'b1;
            state         <= ST_ACK;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= ERR_DAT;
          end else tmo_cnt <= tmo_cnt + 8'd1;
        end

        ST_RADDR: begin
          if (bus.arready) begin
            bus.arvalid <= 1'b0;
            bus.rready  <= 1'b1;
            tmo_cnt     <= '0;
            state       <= ST_RDATA;
          end else if (tmo_hit) begin
            bus.arvalid   <= 1'b0;
            err           <= 1'b1;
            state         <= ST_ACK;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= ERR_DAT;
          end else tmo_cnt <= tmo_cnt + 8'd1;
        end

        ST_RDATA: begin
          if (bus.rvalid) begin
            bus.rready    <= 1'b0;
            state         <= ST_ACK;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= bus.rdata;
          end else if (tmo_hit) begin
            bus.rready    <= 1'b0;
            err           <= 1'b1;
            state         <= ST_ACK;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= ERR_DAT;
          end else tmo_cnt <= tmo_cnt + 8'd1;
        end

        ST_SSWAIT: begin
          if (!fifo_full) begin
            state         <= ST_ACK;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= '0;
          end else if (tmo_hit) begin
            err           <= 1'b1;
            state         <= ST_ACK;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= ERR_DAT;
          end else tmo_cnt <= tmo_cnt + 8'd1;
        end

        ST_SMWAIT: begin
          if (bus.sm_tvalid) begin
            sm_last       <= bus.sm_tlast;
            state         <= ST_ACK;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= bus.sm_tdata;
          end else if (tmo_hit) begin
            err           <= 1'b1;
            state         <= ST_ACK;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= ERR_DAT;
          end else tmo_cnt <= tmo_cnt + 8'd1;
        end

        ST_ACK: begin
          bus.wbs_ack_o <= 1'b0;
          bus.wbs_dat_o <= '0;
          state         <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_axi_bridge.sv
// tb_wb_axi_bridge: drives Wishbone transactions, models the AXI-Lite slave
// and AXIS peers, and checks ack data / latency against a scoreboard.
module tb_wb_axi_bridge;
  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;

  wb_axi_bridge_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus();

  wb_axi_bridge dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int total = 0, bad = 0;
  int cyc = 0, last_t0 = 0;
  int aw_dly = 0, aw_cnt = 0;
  bit ar_en = 1'b1, r_en = 1'b1, r_pend = 1'b0;
  logic [31:0] rd_val = '0;
  int aw_hs = -1, w_hs = -1, ss_n = 0;
  logic [11:0] aw_a = '0, ar_a = '0;
  logic [31:0] w_d = '0;
  logic [3:0]  w_s = '0;
  logic [32:0] ss_q[$];
  logic [31:0] exp_q[$];
  logic [32:0] ss_e;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // AXI-Lite slave: programmable AW delay, W immediate, AR gated by ar_en,
  // R one cycle after the AR handshake when r_en.
  always @(negedge wb_clk_i) begin
    if (bus.awvalid) begin
      bus.awready = (aw_cnt >= aw_dly);
      aw_cnt++;
    end else begin
      bus.awready = 1'b0;
      aw_cnt = 0;
    end
    bus.wready  = bus.wvalid;
    bus.arready = bus.arvalid && ar_en;
    bus.rvalid  = r_pend && r_en;
    bus.rdata   = r_pend ? rd_val : 32'd0;
  end

  // Handshake monitor and stream-out scoreboard.
  always @(posedge wb_clk_i) begin
    if (wb_rst_i) r_pend = 1'b0;
    else begin
      if (bus.awvalid && bus.awready) begin aw_hs = cyc; aw_a = bus.awaddr; end
      if (bus.wvalid && bus.wready) begin w_hs = cyc; w_d = bus.wdata; w_s = bus.wstrb; end
      if (bus.arvalid && bus.arready) begin ar_a = bus.araddr; r_pend = 1'b1; end
      if (bus.rvalid && bus.rready) r_pend = 1'b0;
      if (bus.ss_tvalid && bus.ss_tready) begin
        ss_n++;
        check("ss_beat_expected", 32'(ss_q.size() > 0), 32'd1);
        if (ss_q.size() > 0) begin
          ss_e = ss_q.pop_front();
          check("ss_data", bus.ss_tdata, ss_e[31:0]);
          check("ss_last", 32'(bus.ss_tlast), 32'(ss_e[32]));
        end
      end
    end
    cyc <= cyc + 1;
  end

  task automatic wb_xfer(string tag, bit we, logic [31:0] adr, logic [31:0] dat,
                         logic [3:0] sel, logic [31:0] exp_d, int exp_lat);
    int lat;
    bit got;
    logic [31:0] e;
    exp_q.push_back(exp_d);
    @(negedge wb_clk_i);
    bus.wb_valid  = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    last_t0 = cyc;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge wb_clk_i);
      if (bus.wbs_ack_o) got = 1'b1;
    end
    lat = cyc - last_t0;
    e = exp_q.pop_front();
    check({tag, "_ack"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_dat"}, bus.wbs_dat_o, e);
      if (exp_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    end
    bus.wb_valid  = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_dat_i = '0;
    bus.wbs_sel_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int aw_before;
    bus.wb_valid  = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_adr_i = '0;
    bus.ss_tready = 1'b0;
    bus.sm_tvalid = 1'b0;
    bus.sm_tdata  = '0;
    bus.sm_tlast  = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
    check("rst_dat", bus.wbs_dat_o, 32'd0);
    check("rst_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.rready,
                             bus.ss_tvalid, bus.sm_tready}), 32'd0);
    wb_rst_i = 1'b0;

    // Write with AW delayed by 2 cycles
    aw_dly = 2;
    wb_xfer("wr_slow", 1'b1, 32'h3000_3010, 32'h1234_5678, 4'b0011, 32'd0, 4);
    check("wr_awaddr", 32'(aw_a), 32'h010);
    check("wr_wstrb", 32'(w_s), 32'h3);
    check("wr_wdata", w_d, 32'h1234_5678);
    check("wr_w_cyc", 32'(w_hs - last_t0), 32'd1);
    check("wr_aw_cyc", 32'(aw_hs - last_t0), 32'd3);
    aw_dly = 0;
    wb_xfer("wr_fast", 1'b1, 32'h3000_3014, 32'hA5A5_0000, 4'b1111, 32'd0, 2);
    check("wr_fast_awaddr", 32'(aw_a), 32'h014);

    // Immediate read
    rd_val = 32'hCAFE_0001;
    wb_xfer("rd", 1'b0, 32'h3000_3020, 32'd0, 4'hF, 32'hCAFE_0001, 3);
    check("rd_araddr", 32'(ar_a), 32'h020);

    // Undecoded and wrong-direction accesses
    aw_before = aw_hs;
    wb_xfer("oow_rd", 1'b0, 32'h3000_4000, 32'd0, 4'hF, 32'd0, 1);
    wb_xfer("oow_wr", 1'b1, 32'h2FFF_FFFC, 32'h1, 4'hF, 32'd0, 1);
    check("oow_no_aw", 32'(aw_hs), 32'(aw_before));
    wb_xfer("ss_rd", 1'b0, 32'h3000_3080, 32'd0, 4'hF, 32'd0, 1);
    wb_xfer("sm_wr", 1'b1, 32'h3000_3084, 32'h7, 4'hF, 32'd0, 1);

    // Stream out: four posted, fifth blocks until the consumer drains
    for (int i = 1; i <= 4; i++) begin
      ss_q.push_back({1'b0, 32'(i)});
      wb_xfer("ss_push", 1'b1, 32'h3000_3080, 32'(i), 4'hF, 32'd0, 1);
      if (i == 1) check("ss_tvalid_rise", 32'(bus.ss_tvalid), 32'd1);
    end
    wb_xfer("stat_cnt", 1'b0, 32'h3000_308C, 32'd0, 4'hF, 32'h0000_0400, 1);
    ss_q.push_back({1'b1, 32'd5});
    fork
      wb_xfer("ss_full", 1'b1, 32'h3000_3088, 32'd5, 4'hF, 32'd0, 7);
      begin
        repeat (6) @(negedge wb_clk_i);
        bus.ss_tready = 1'b1;
      end
    join
    for (int i = 0; i < 50 && ss_q.size() > 0; i++) @(negedge wb_clk_i);
    check("ss_drain", 32'(ss_n), 32'd5);

    // Stream in: data arrives after 10 cycles
    fork
      wb_xfer("sm_pop", 1'b0, 32'h3000_3084, 32'd0, 4'hF, 32'h0000_00AB, 11);
      begin
        repeat (11) @(negedge wb_clk_i);
        bus.sm_tvalid = 1'b1;
        bus.sm_tdata  = 32'hAB;
        bus.sm_tlast  = 1'b1;
        @(negedge wb_clk_i);
        bus.sm_tvalid = 1'b0;
        bus.sm_tdata  = '0;
        bus.sm_tlast  = 1'b0;
      end
    join
    wb_xfer("stat_last", 1'b0, 32'h3000_308C, 32'd0, 4'hF, 32'h0000_0002, 1);

    // Timeout on a stuck AR channel
    ar_en = 1'b0;
    wb_xfer("tmo", 1'b0, 32'h3000_3020, 32'd0, 4'hF, 32'hDEAD_BEEF, 256);
    check("tmo_arvalid", 32'(bus.arvalid), 32'd0);
    ar_en = 1'b1;
    wb_xfer("stat_err", 1'b0, 32'h3000_308C, 32'd0, 4'hF, 32'h0000_0003, 1);
    wb_xfer("stat_clr", 1'b1, 32'h3000_308C, 32'd1, 4'hF, 32'd0, 1);
    wb_xfer("stat_after", 1'b0, 32'h3000_308C, 32'd0, 4'hF, 32'h0000_0002, 1);

    // Reset while waiting in RDATA, with a word parked in the FIFO
    bus.ss_tready = 1'b0;
    ss_q.push_back({1'b0, 32'd9});
    wb_xfer("ss_pre", 1'b1, 32'h3000_3080, 32'd9, 4'hF, 32'd0, 1);
    r_en = 1'b0;
    @(negedge wb_clk_i);
    bus.wb_valid  = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = 32'h3000_3030;
    repeat (3) @(negedge wb_clk_i);
    check("pre_rst_rready", 32'(bus.rready), 32'd1);
    #2 wb_rst_i = 1'b1;
    #1;
    check("mid_rst_outs", 32'({bus.wbs_ack_o, bus.awvalid, bus.wvalid, bus.arvalid,
                               bus.rready, bus.ss_tvalid, bus.sm_tready}), 32'd0);
    check("mid_rst_dat", bus.wbs_dat_o | bus.ss_tdata, 32'd0);
    bus.wb_valid = 1'b0;
    ss_q.delete();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    r_en = 1'b1;
    bus.ss_tready = 1'b1;
    rd_val = 32'h5555_AAAA;
    wb_xfer("post_rst", 1'b0, 32'h3000_3040, 32'd0, 4'hF, 32'h5555_AAAA, 3);
    check("flushed", 32'(ss_n), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
